// File: rtl/alu_sched_pkg.sv
// alu_sched shared types and constants.
// FSM state encoding, op-select width and perf counter width.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_sched_state_t;

  localparam int SEL_W  = 3;
  localparam int PERF_W = 16;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU: add/sub/and/or/xor/shl/shr/not.
// Carry is carry-out for add, no-borrow for sub, shifted-out bit for shifts.
module alu
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] y,
  output logic             c
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;

  // Decode the op select into result and carry.
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    y   = '0;
    c   = 1'b0;
    case (sel)
      3'b000: begin
        y = sum[WIDTH-1:0];
        c = sum[WIDTH];
      end
      3'b001: begin
        y = dif[WIDTH-1:0];
        c = dif[WIDTH];
      end
      3'b010: y = a & b;
      3'b011: y = a | b;
      3'b100: y = a ^ b;
      3'b101: begin
        y = {a[WIDTH-2:0], 1'b0};
        c = a[WIDTH-1];
      end
      3'b110: begin
        y = {1'b0, a[WIDTH-1:1]};
        c = a[0];
      end
      default: y = ~a;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches from prio upward, modulo NUM_REQ; first set request wins.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     prio,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id
);

  logic           found;
  logic [IDW-1:0] idx;

  // Rotating priority search starting at prio.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(prio) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one alu among NUM_REQ requesters.
// Optional perf counters (perf_ops, perf_stall) under ALU_SCHED_PERF_EN.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter  int WIDTH   = 4,
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*SEL_W-1:0] req_sel,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_y,
  output logic                     resp_c,
  output logic [IDW-1:0]           resp_id,
  output logic                     busy
`ifdef ALU_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0]        perf_ops,
  output logic [PERF_W-1:0]        perf_stall
`endif
);

  alu_sched_state_t state;
  alu_sched_state_t state_n;

  logic [IDW-1:0]     prio;
  logic [IDW-1:0]     prio_n;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic               acc;

  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [SEL_W-1:0] sel_s;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [SEL_W-1:0] op_sel;
  logic [IDW-1:0]   op_id;

  logic [WIDTH-1:0] alu_y;
  logic             alu_c;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req   (req_valid),
    .prio  (prio),
    .gnt   (gnt),
    .gnt_id(gnt_id)
  );

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a  (op_a),
    .b  (op_b),
    .sel(op_sel),
    .y  (alu_y),
    .c  (alu_c)
  );

  // Route the granted requester's payload to the operation registers.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
        sel_s = req_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  // Pointer moves past the winner, wrapping at NUM_REQ-1.
  always_comb begin
    prio_n = gnt_id + IDW'(1);
    if (gnt_id == IDW'(NUM_REQ-1)) begin
      prio_n = '0;
    end
  end

  // FSM next state and accept strobe; reset blocks acceptance.
  always_comb begin
    state_n = state;
    acc     = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid && !rst) begin
          acc     = 1'b1;
          state_n = EXEC;
        end
      end
      EXEC: state_n = RESP;
      RESP: begin
        if (resp_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign req_ready  = acc ? gnt : '0;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Capture the granted operation and advance the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio   <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_sel <= '0;
      op_id  <= '0;
    end else if (acc) begin
      prio   <= prio_n;
      op_a   <= sel_a;
      op_b   <= sel_b;
      op_sel <= sel_s;
      op_id  <= gnt_id;
    end
  end

  // Register the ALU result at the end of EXEC; held through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_y  <= '0;
      resp_c  <= 1'b0;
      resp_id <= '0;
    end else if (state == EXEC) begin
      resp_y  <= alu_y;
      resp_c  <= alu_c;
      resp_id <= op_id;
    end
  end

`ifdef ALU_SCHED_PERF_EN
  // Completed handshakes (wrapping) and RESP stall cycles (saturating).
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (resp_valid && resp_ready) begin
        perf_ops <= perf_ops + PERF_W'(1);
      end
      if (resp_valid && !resp_ready && perf_stall != '1) begin
        perf_stall <= perf_stall + PERF_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: reset, RR order, wrap, stall,
// reset in EXEC and a random soak against a reference ALU model.
module tb_alu_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [11:0] req_sel;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [3:0]  resp_y;
  logic        resp_c;
  logic [1:0]  resp_id;
  logic        busy;
`ifdef ALU_SCHED_PERF_EN
  logic [15:0] perf_ops;
  logic [15:0] perf_stall;
`endif

  int chk;
  int pass;

  alu_sched #(
    .WIDTH  (4),
    .NUM_REQ(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_y    (resp_y),
    .resp_c    (resp_c),
    .resp_id   (resp_id),
    .busy      (busy)
`ifdef ALU_SCHED_PERF_EN
    ,
    .perf_ops  (perf_ops),
    .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU written arithmetically; returns {c, y}.
  function automatic logic [4:0] ref_alu(input int a, input int b,
                                         input int s);
    int y;
    int c;
    logic [3:0] av;
    logic [3:0] bv;
    av = 4'(a);
    bv = 4'(b);
    y = 0;
    c = 0;
    case (s)
      0: begin y = (a + b) % 16; c = (a + b > 15) ? 1 : 0; end
      1: begin y = (a - b + 16) % 16; c = (a >= b) ? 1 : 0; end
      2: y = int'(av & bv);
      3: y = int'(av | bv);
      4: y = int'(av ^ bv);
      5: begin y = (a * 2) % 16; c = (a > 7) ? 1 : 0; end
      6: begin y = a / 2; c = a % 2; end
      default: y = 15 - a;
    endcase
    return {1'(c), 4'(y)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b,
                        input int s);
    req_a[i*4 +: 4]   = 4'(a);
    req_b[i*4 +: 4]   = 4'(b);
    req_sel[i*3 +: 3] = 3'(s);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = 4'b1111;
    resp_ready = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_sel    = '0;
    step();
    step();
    chk++;
    if (req_ready !== 4'b0000)
      $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    else pass++;
    req_valid = '0;
    rst = 1'b0;
    #1;
    chk++;
    if ({resp_valid, resp_y, resp_c, resp_id, busy} !== 9'd0)
      $display("FAIL reset_outputs: got v%b y%h c%b id%0d busy%b want 0",
               resp_valid, resp_y, resp_c, resp_id, busy);
    else pass++;
`ifdef ALU_SCHED_PERF_EN
    chk++;
    if (perf_ops !== 16'd0 || perf_stall !== 16'd0)
      $display("FAIL reset_perf: got ops %0d stall %0d want 0 0",
               perf_ops, perf_stall);
    else pass++;
`endif
  endtask

  task automatic test_single();
    logic [4:0] e;
    e = ref_alu(3, 5, 0);
    set_op(0, 3, 5, 0);
    req_valid = 4'b0001;
    #1;
    chk++;
    if (req_ready !== 4'b0001)
      $display("FAIL single_grant: got %b want 0001", req_ready);
    else pass++;
    step();
    req_valid = '0;
    #1;
    chk++;
    if (req_ready !== 4'b0000 || resp_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL single_exec: got rdy %b v %b busy %b want 0000 0 1",
               req_ready, resp_valid, busy);
    else pass++;
    step();
    chk++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd0 ||
        {resp_c, resp_y} !== e)
      $display("FAIL single_resp: got v%b id%0d c%b y%h want 1 0 %b %h",
               resp_valid, resp_id, resp_c, resp_y, e[4], e[3:0]);
    else pass++;
    resp_ready = 1'b1;
    step();
    chk++;
    if (resp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL single_done: got v%b busy%b want 0 0",
               resp_valid, busy);
    else pass++;
  endtask

  task automatic test_rr_order();
    logic [4:0] e;
    int w;
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, i * 3 + 2, i + 7, i);
    resp_ready = 1'b1;
    req_valid  = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      w = g % 4;
      e = ref_alu(w * 3 + 2, w + 7, w);
      chk++;
      if (req_ready !== 4'(1 << w))
        $display("FAIL rr_grant%0d: got %b want %b", g, req_ready,
                 4'(1 << w));
      else pass++;
      step();
      step();
      chk++;
      if (resp_valid !== 1'b1 || resp_id !== 2'(w) ||
          {resp_c, resp_y} !== e)
        $display("FAIL rr_resp%0d: got v%b id%0d cy%b want 1 %0d %b",
                 g, resp_valid, resp_id, {resp_c, resp_y}, w, e);
      else pass++;
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    resp_ready = 1'b1;
    set_op(3, 1, 1, 2);
    set_op(0, 4, 4, 3);
    req_valid = 4'b1000;
    #1;
    chk++;
    if (req_ready !== 4'b1000)
      $display("FAIL wrap_grant3: got %b want 1000", req_ready);
    else pass++;
    step();
    req_valid = '0;
    step();
    chk++;
    if (resp_id !== 2'd3 || {resp_c, resp_y} !== 5'b0_0001)
      $display("FAIL wrap_resp3: got id%0d cy%b want 3 00001",
               resp_id, {resp_c, resp_y});
    else pass++;
    step();
    req_valid = 4'b1001;
    #1;
    chk++;
    if (req_ready !== 4'b0001)
      $display("FAIL wrap_grant0: got %b want 0001", req_ready);
    else pass++;
    step();
    req_valid = '0;
    step();
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_op(2, 9, 9, 0);
    req_valid = 4'b0100;
    #1;
    chk++;
    if (req_ready !== 4'b0100)
      $display("FAIL bp_grant: got %b want 0100", req_ready);
    else pass++;
    step();
    req_valid = '0;
    step();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk++;
      if (resp_valid !== 1'b1 || resp_y !== 4'h2 || resp_c !== 1'b1 ||
          resp_id !== 2'd2 || req_ready !== 4'b0000)
        $display("FAIL bp_hold%0d: got v%b y%h c%b id%0d rdy%b want 1 2 1 2 0000",
                 k, resp_valid, resp_y, resp_c, resp_id, req_ready);
      else pass++;
      step();
    end
    chk++;
    if (resp_valid !== 1'b1)
      $display("FAIL bp_still_valid: got %b want 1", resp_valid);
    else pass++;
`ifdef ALU_SCHED_PERF_EN
    chk++;
    if (perf_stall !== 16'd5)
      $display("FAIL bp_stall_cnt: got %0d want 5", perf_stall);
    else pass++;
`endif
    req_valid  = '0;
    resp_ready = 1'b1;
    step();
    chk++;
    if (resp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL bp_release: got v%b busy%b want 0 0",
               resp_valid, busy);
    else pass++;
`ifdef ALU_SCHED_PERF_EN
    chk++;
    if (perf_ops !== 16'd1 || perf_stall !== 16'd5)
      $display("FAIL bp_perf: got ops %0d stall %0d want 1 5",
               perf_ops, perf_stall);
    else pass++;
`endif
  endtask

  task automatic test_reset_exec();
    bit seen;
    set_op(1, 6, 2, 1);
    req_valid = 4'b0010;
    #1;
    chk++;
    if (req_ready !== 4'b0010)
      $display("FAIL rexec_grant: got %b want 0010", req_ready);
    else pass++;
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    resp_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (resp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      step();
    end
    chk++;
    if (seen)
      $display("FAIL rexec_no_resp: got resp/busy 1 want 0");
    else pass++;
    req_valid = 4'b1111;
    #1;
    chk++;
    if (req_ready !== 4'b0001)
      $display("FAIL rexec_prio: got %b want 0001", req_ready);
    else pass++;
    req_valid = '0;
    #1;
  endtask

  task automatic test_soak();
    logic [6:0] q[$];
    logic [6:0] hd;
    logic [4:0] e;
    bit   pend[4];
    int   pa[4];
    int   pb[4];
    int   ps[4];
    int   wt[4];
    int   mprio;
    int   created;
    int   done;
    int   cyc;
    int   w;
    bit   bad;
    do_reset();
    mprio   = 0;
    created = 0;
    done    = 0;
    cyc     = 0;
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b0;
      wt[i]   = 0;
    end
    while (done < 200 && cyc < 20000) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && created < 200 && $urandom_range(3, 0) == 0) begin
          pend[i] = 1'b1;
          pa[i]   = int'($urandom_range(15, 0));
          pb[i]   = int'($urandom_range(15, 0));
          ps[i]   = int'($urandom_range(7, 0));
          created++;
        end
        req_valid[i] = pend[i];
        set_op(i, pa[i], pb[i], ps[i]);
      end
      resp_ready = ($urandom_range(3, 0) != 0);
      #1;
      if (resp_valid && resp_ready) begin
        chk++;
        if (q.size() == 0) begin
          $display("FAIL soak_unexpected_resp: got id%0d want none",
                   resp_id);
        end else begin
          hd = q.pop_front();
          if ({resp_id, resp_c, resp_y} !== hd)
            $display("FAIL soak_resp%0d: got id%0d cy%b want id%0d cy%b",
                     done, resp_id, {resp_c, resp_y}, hd[6:5], hd[4:0]);
          else pass++;
        end
        done++;
      end
      if (req_ready != 4'b0000) begin
        w = -1;
        for (int k = 0; k < 4; k++) begin
          if (w < 0 && pend[(mprio + k) % 4]) w = (mprio + k) % 4;
        end
        chk++;
        if (w < 0 || req_ready !== 4'(1 << w)) begin
          $display("FAIL soak_grant: got %b want %b", req_ready,
                   (w < 0) ? 4'b0000 : 4'(1 << w));
        end else begin
          pass++;
          e = ref_alu(pa[w], pb[w], ps[w]);
          q.push_back({2'(w), e});
          bad = 1'b0;
          for (int j = 0; j < 4; j++) begin
            if (j != w && pend[j]) begin
              wt[j]++;
              if (wt[j] > 3) bad = 1'b1;
            end
          end
          wt[w]   = 0;
          pend[w] = 1'b0;
          mprio   = (w + 1) % 4;
          chk++;
          if (bad) $display("FAIL soak_fairness: got wait>3 want <=3");
          else pass++;
        end
      end
      step();
      cyc++;
    end
    chk++;
    if (done != 200)
      $display("FAIL soak_timeout: got %0d responses want 200", done);
    else pass++;
    req_valid  = '0;
    resp_ready = 1'b0;
  endtask

  initial begin
    chk  = 0;
    pass = 0;
    test_reset();
    test_single();
    test_rr_order();
    test_wrap();
    test_backpressure();
    test_reset_exec();
    test_soak();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares one instance of the team's combinational `alu` (operands `a`, `b`, op select `sel[2:0]`, result `y`, carry `c`) among `NUM_REQ` requesters. It accepts one operation at a time over a valid/ready handshake and registers operands into the ALU. It returns the registered result and carry, tagged with the requester index, over a second valid/ready handshake. It sits between requesting datapath blocks and the single ALU.

## Interface
- `WIDTH`, 4: operand/result width, passed to `alu`.
- `NUM_REQ`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(NUM_REQ)`: requester-index width; derived, not overridden.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NUM_REQ: bit i set means requester i presents an operation.
- `req_a` input NUM_REQ*WIDTH: operand a; requester i occupies slice [i*WIDTH +: WIDTH].
- `req_b` input NUM_REQ*WIDTH: operand b, same packing as `req_a`.
- `req_sel` input NUM_REQ*3: op select; slice [i*3 +: 3], passed to the ALU opaquely.
- `req_ready` output NUM_REQ: one-hot acceptance strobe; bit i high means requester i's operation is taken this cycle.
- `resp_valid` output 1: result available.
- `resp_ready` input 1: consumer accepts the result.
- `resp_y` output WIDTH: registered ALU result.
- `resp_c` output 1: registered ALU carry.
- `resp_id` output IDW: index of the requester that owns the result.
- `busy` output 1: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE, ready to accept.
  - EXEC, registered operands drive the ALU.
  - RESP, result held.
- IDLE with `req_valid != 0`:
  - Grant the winner w and assert `req_ready[w]` combinationally that cycle.
  - Capture `a`, `b`, `sel` and w into operation registers.
  - Go to EXEC.
- IDLE with `req_valid == 0`: stay in IDLE; `req_ready` is 0.
- EXEC: the ALU sees only the operation registers. At the cycle end, capture `y` into `resp_y`, `c` into `resp_c` and w into `resp_id`, then go to RESP. EXEC always lasts exactly one cycle.
- RESP: `resp_valid`=1, and `resp_*` holds stable until `resp_valid && resp_ready`; then go to IDLE.
- `req_ready` is 0 in EXEC and RESP. A requester must hold its valid and payload until it sees its ready bit.
- Round-robin:
  - Pointer `prio` (IDW bits) names the highest-priority requester. Search `prio`, `prio+1`, … modulo NUM_REQ; the first set `req_valid` wins.
  - After a grant to w, `prio` ← (w+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
  - `prio` changes only on a grant.
- Simultaneous requests: exactly one grant per accept cycle. No requester is skipped more than NUM_REQ-1 consecutive grants while it holds valid.
- A requester dropping valid before it is granted is legal; it loses its turn without affecting `prio`.
- Reset mid-operation: an in-flight operation is discarded and no response is produced.
- Reset values: FSM IDLE, `prio`=0, `resp_valid`=0, `resp_y`=0, `resp_c`=0, `resp_id`=0, `busy`=0, `req_ready`=0.

## Timing
- Accept to `resp_valid`: 2 cycles. Accept in cycle T, EXEC in T+1, `resp_valid` high from T+2.
- Minimum issue interval: 3 cycles (accept, EXEC, RESP with `resp_ready` already high). The next accept can occur in the cycle after the response handshake.
- `resp_ready` low stalls in RESP indefinitely with outputs stable.
- `req_ready` depends combinationally on `req_valid` and state. No combinational path from `resp_ready` to `req_ready`.

## Configuration
- Macro `ALU_SCHED_PERF_EN` defined:
  - Adds output `perf_ops` (16 bits): completed response handshakes, wrapping at 16'hFFFF→0.
  - Adds output `perf_stall` (16 bits): cycles in RESP with `resp_ready`=0, saturating at 16'hFFFF.
  - Both counters reset to 0.
- Macro undefined: neither port nor the counter logic exists. All other behaviour is identical.

## Structure
- Package `alu_sched_pkg`:
  - FSM state enum `alu_sched_state_t` {IDLE, EXEC, RESP}.
  - Constant `SEL_W`=3.
  - Perf counter width constant `PERF_W`=16.
- Sub-module `rr_arbiter`:
  - Parameter NUM_REQ.
  - Inputs `req` and `prio`; outputs one-hot `gnt` and `gnt_id`.
  - Purely combinational. The pointer register lives in `alu_sched`.
- `alu_sched` instantiates `rr_arbiter` and one `alu`.

## Test plan
- Reset, then single request: hold `rst` 2 cycles; `req_valid`=4'b0001, a=3, b=5, sel=3'b000 → `req_ready`=4'b0001 one cycle; 2 cycles later `resp_valid`=1, `resp_id`=0, `resp_y`/`resp_c` match the `alu` reference model for (3,5,000).
- All four requesting continuously, `resp_ready`=1 → grants in order 0,1,2,3,0; one response every 3 cycles; each `resp_id` matches its grant order.
- Pointer wrap: after a grant to 3, assert `req_valid`=4'b1001 → requester 0 wins.
- Backpressure: hold `resp_ready`=0 for 5 cycles in RESP → `resp_y`, `resp_c`, `resp_id` stable, `req_ready`=0 throughout. Response completes on the first `resp_ready`=1 cycle. With `ALU_SCHED_PERF_EN`: `perf_stall`=5, `perf_ops`=1.
- Reset during EXEC: accept an operation, assert `rst` in the next cycle → no `resp_valid` ever produced for it; `prio`=0 and IDLE afterwards.
- Randomized soak: 200 random operations (a, b in 0..15, sel 0..7, random valid and `resp_ready`). Every response matches the `alu` model and is tagged with the correct requester; no requester waits more than 3 grants.
